axis_tx_buffer: RTL

- Store-and-forward buffer on the PCIe transmit path, between our TX TLP formatting logic (slave side) and the PCIe core's s_axis_tx interface (master side).
- Presents a TLP to the core only after the whole TLP is held locally, so m_axis_tx_tvalid never drops mid-packet. This meets the core's no-gap TX requirement.
- Also isolates core not-ready stalls from the TX formatting logic.

---
 rtl/axis_tx_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/axis_tx_buffer.sv
// Store-and-forward TLP buffer between TX formatting logic and the PCIe core's s_axis_tx port.
// A TLP is offered downstream only once fully stored, so tvalid never gaps mid-packet.
module axis_tx_buffer #(
    parameter int unsigned DEPTH_LOG2    = 9,
    parameter int unsigned MAX_PKT_BEATS = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [127:0]          s_axis_tx_tdata,
    input  logic [15:0]           s_axis_tx_tkeep,
    input  logic                  s_axis_tx_tlast,
    input  logic [3:0]            s_axis_tx_tuser,
    input  logic                  s_axis_tx_tvalid,
    output logic                  s_axis_tx_tready,
    output logic [127:0]          m_axis_tx_tdata,
    output logic [15:0]           m_axis_tx_tkeep,
    output logic                  m_axis_tx_tlast,
    output logic [3:0]            m_axis_tx_tuser,
    output logic                  m_axis_tx_tvalid,
    input  logic                  m_axis_tx_tready,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   pkt_count,
    output logic                  oversize_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [3:0]   user;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          mid_out_q, mid_out_d;
    logic          out_vld_q, out_vld_d;
    logic          ovf_err_q, ovf_err_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    beat_t         out_q;

    beat_t         mem [DEPTH];
    beat_t         ram_wdata;
    logic          ram_we;
    logic          load;
    logic          oversize;
    logic          wr;
    logic          rd;
    logic [CW-1:0] free_d;

    assign wr = s_axis_tx_tvalid & s_ready_q;
    assign rd = m_valid_q & m_axis_tx_tready;

    // Inbound FSM, pointer/counter bookkeeping and output-stage control
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        mid_out_d  = mid_out_q;
        ovf_err_d  = ovf_err_q;
        ram_we     = 1'b0;
        ram_wdata.data = s_axis_tx_tdata;
        ram_wdata.keep = s_axis_tx_tkeep;
        ram_wdata.last = s_axis_tx_tlast;
        ram_wdata.user = s_axis_tx_tuser;
        oversize   = wr && !s_axis_tx_tlast && (state_q != ST_DROP)
                     && (beat_cnt_q == CW'(MAX_PKT_BEATS - 1));

        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (wr) begin
                    ram_we            = 1'b1;
                    ram_wdata.last    = s_axis_tx_tlast | oversize;
                    ram_wdata.user[3] = s_axis_tx_tuser[3] | oversize;
                    if (oversize) begin
                        state_d    = ST_DROP;
                        beat_cnt_d = '0;
                        ovf_err_d  = 1'b1;
                    end else if (s_axis_tx_tlast) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        state_d    = ST_ACC;
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            ST_DROP: begin
                if (wr && s_axis_tx_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d  = wr_ptr_q + PW'(ram_we);
        // Refill the output register whenever RAM holds a beat and the register is free or draining
        load      = (level_q > CW'(out_vld_q)) && (!out_vld_q || rd);
        rd_ptr_d  = rd_ptr_q + PW'(load);
        out_vld_d = load || (out_vld_q && !rd);
        level_d   = level_q + CW'(ram_we) - CW'(rd);
        pkt_cnt_d = pkt_cnt_q + CW'(ram_we && ram_wdata.last) - CW'(rd && out_q.last);
        if (rd) begin
            mid_out_d = !out_q.last;
        end

        free_d = CW'(DEPTH) - level_d;
        case (state_d)
            ST_IDLE: s_ready_d = (free_d >= CW'(MAX_PKT_BEATS));
            ST_ACC:  s_ready_d = (free_d != '0);
            default: s_ready_d = 1'b1;
        endcase

        m_valid_d = out_vld_d && ((pkt_cnt_d != '0) || mid_out_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pkt_cnt_q  <= '0;
            mid_out_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pkt_cnt_q  <= pkt_cnt_d;
            mid_out_q  <= mid_out_d;
            out_vld_q  <= out_vld_d;
            ovf_err_q  <= ovf_err_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr_q] <= ram_wdata;
        end
    end

    // RAM read port lands directly in the output register (first-word fall-through)
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (load) begin
            out_q <= mem[rd_ptr_q];
        end
    end

    assign s_axis_tx_tready = s_ready_q;
    assign m_axis_tx_tvalid = m_valid_q;
    assign m_axis_tx_tdata  = out_q.data;
    assign m_axis_tx_tkeep  = out_q.keep;
    assign m_axis_tx_tlast  = out_q.last;
    assign m_axis_tx_tuser  = out_q.user;
    assign level            = level_q;
    assign pkt_count        = pkt_cnt_q;
    assign oversize_err     = ovf_err_q;

endmodule
